// File: rtl/alu16.sv
// alu16: registered adder with sign/zero/carry/parity/overflow flags; define ALU16_SUB_EN to add a subtract port.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
`ifdef ALU16_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] Z,
  output logic             S,
  output logic             ZR,
  output logic             CY,
  output logic             P,
  output logic             V,
  output logic             out_valid
);
  logic             sub_w;
  logic [WIDTH-1:0] ye, r;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] z_q, z_d;
  logic             s_q, s_d, zr_q, zr_d, cy_q, cy_d, p_q, p_d, v_q, v_d, ov_q, ov_d;
`ifdef ALU16_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif
  // subtraction is X + ~Y + 1; the carry out is then the inverse of the borrow
  always_comb begin
    ye   = sub_w ? ~Y : Y;
    sum  = {1'b0, X} + {1'b0, ye} + {{WIDTH{1'b0}}, sub_w};
    r    = sum[WIDTH-1:0];
    z_d  = in_valid ? r : z_q;
    s_d  = in_valid ? r[WIDTH-1] : s_q;
    zr_d = in_valid ? (r == '0) : zr_q;
    cy_d = in_valid ? (sum[WIDTH] ^ sub_w) : cy_q;
    p_d  = in_valid ? ~^r : p_q;
    v_d  = in_valid ? ((X[WIDTH-1] == ye[WIDTH-1]) && (r[WIDTH-1] != X[WIDTH-1])) : v_q;
    ov_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q  <= '0;
      s_q  <= 1'b0;
      zr_q <= 1'b0;
      cy_q <= 1'b0;
      p_q  <= 1'b0;
      v_q  <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      z_q  <= z_d;
      s_q  <= s_d;
      zr_q <= zr_d;
      cy_q <= cy_d;
      p_q  <= p_d;
      v_q  <= v_d;
      ov_q <= ov_d;
    end
  end
  assign Z         = z_q;
  assign S         = s_q;
  assign ZR        = zr_q;
  assign CY        = cy_q;
  assign P         = p_q;
  assign V         = v_q;
  assign out_valid = ov_q;
endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed vectors with literal expectations plus an arithmetic reference model checked every negedge.
module tb_alu16;
`ifdef ALU16_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [15:0] X, Y, Z;
  logic sub_i, S, ZR, CY, P, V, out_valid;
  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;
  logic [15:0] m_z;
  logic m_s, m_zr, m_cy, m_p, m_v, m_ov;
  int a, b, sa, sb, res, sres;
  logic es;
  logic [21:0] outs, mexp;

  alu16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .X(X), .Y(Y),
`ifdef ALU16_SUB_EN
    .sub(sub_i),
`endif
    .Z(Z), .S(S), .ZR(ZR), .CY(CY), .P(P), .V(V), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  assign outs = {Z, S, ZR, CY, P, V, out_valid};
  assign mexp = {m_z, m_s, m_zr, m_cy, m_p, m_v, m_ov};

  // reference: plain integer arithmetic on unsigned and signed interpretations
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_z, m_s, m_zr, m_cy, m_p, m_v, m_ov} <= '0;
    end else if (in_valid) begin
      es   = sub_i & SUB_EN;
      a    = int'(X);
      b    = int'(Y);
      sa   = int'($signed(X));
      sb   = int'($signed(Y));
      res  = es ? a - b : a + b;
      sres = es ? sa - sb : sa + sb;
      m_z  <= res[15:0];
      m_s  <= res[15];
      m_zr <= (res[15:0] == 16'h0);
      m_cy <= es ? (a < b) : (res > 65535);
      m_p  <= ($countones(res[15:0]) % 2) == 0;
      m_v  <= (sres > 32767) || (sres < -32768);
      m_ov <= 1'b1;
    end else begin
      m_ov <= 1'b0;
    end
  end

  task automatic chk(input string n, input logic [21:0] act, input logic [21:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got Z=%h flags(S,ZR,CY,P,V,ov)=%b, expected Z=%h flags=%b",
               n, act[21:6], act[5:0], exp[21:6], exp[5:0]);
    end
  endtask

  always @(negedge clk) if (run) chk("model", outs, mexp);

  task automatic step(input logic [15:0] x, input logic [15:0] y, input logic s, input logic v);
    X = x;
    Y = y;
    sub_i = s;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    X = '0;
    Y = '0;
    sub_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs, 22'h0);
    rst_n = 1'b1;
    run = 1'b1;
    step(16'h8FFF, 16'h8000, 1'b0, 1'b1);
    chk("r025", outs, {16'h0FFF, 6'b001111});
    step(16'hFFFE, 16'h0002, 1'b0, 1'b1);
    chk("r026", outs, {16'h0000, 6'b011101});
    step(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    chk("r027a", outs, {16'hFFFF, 6'b100101});
    step(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    chk("r027b", outs, {16'h8000, 6'b100011});
    for (int i = 0; i < 3; i++) begin
      step(16'h1234, 16'h4321, 1'b0, 1'b0);
      chk("idle_hold", outs, {16'h8000, 6'b100010});
    end
    step(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    chk("pre_reset", outs, {16'hFFFF, 6'b100101});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs, 22'h0);
    #3 rst_n = 1'b1;
    step(16'h0001, 16'h0001, 1'b0, 1'b1);
    chk("r029", outs, {16'h0002, 6'b000001});
    step(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("zero_add", outs, {16'h0000, 6'b010101});
    step(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    chk("ffff_add", outs, {16'hFFFE, 6'b101001});
    step(16'h8000, 16'h8000, 1'b0, 1'b1);
    step(16'h4000, 16'h4000, 1'b0, 1'b1);
    step(16'h1357, 16'h2468, 1'b0, 1'b1);
    step(16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
`ifdef ALU16_SUB_EN
    step(16'h0001, 16'h0002, 1'b1, 1'b1);
    chk("r030a", outs, {16'hFFFF, 6'b101101});
    step(16'h8000, 16'h0001, 1'b1, 1'b1);
    chk("r030b", outs, {16'h7FFF, 6'b000011});
    step(16'h5555, 16'h5555, 1'b1, 1'b1);
    chk("sub_eq", outs, {16'h0000, 6'b010101});
    step(16'h7FFF, 16'hFFFF, 1'b1, 1'b1);
    step(16'h1234, 16'h0034, 1'b1, 1'b1);
    step(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    chk("sub0_add", outs, {16'h8000, 6'b100011});
`endif
    step(16'h0000, 16'h0000, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu16.md
ALU16 -- requirements
Module: alu16

Interface
REQ-001 The module SHALL declare parameter WIDTH, default 16, giving the operand and result width; only 16 is required to be supported.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port in_valid: input, 1 bit; operands are sampled when it is high.
REQ-006 Port X: input, WIDTH bits, operand A.
REQ-007 Port Y: input, WIDTH bits, operand B.
REQ-008 Port sub: input, 1 bit, operation select (0 = add, 1 = subtract); present only with ALU16_SUB_EN (see REQ-024).
REQ-009 Port Z: output, WIDTH bits, registered result.
REQ-010 Port S: output, 1 bit, sign flag.
REQ-011 Port ZR: output, 1 bit, zero flag.
REQ-012 Port CY: output, 1 bit, carry (or borrow) flag.
REQ-013 Port P: output, 1 bit, parity flag.
REQ-014 Port V: output, 1 bit, signed-overflow flag.
REQ-015 Port out_valid: output, 1 bit, high for exactly one cycle per accepted operation.

Function
REQ-016 On each rising clk edge with in_valid=1, the add result SHALL be computed and registered:
- sum = X + Y, evaluated as a WIDTH+1-bit value
- Z = sum[WIDTH-1:0], so the result wraps modulo 2^WIDTH
- CY = sum[WIDTH]
REQ-017 The flags SHALL be registered in the same cycle as Z:
- S = Z[WIDTH-1]
- ZR = 1 when Z is all zeros
- P = 1 when Z contains an even number of ones (even parity; P=1 for Z=0)
- V = 1 when X and Y have the same sign bit and Z's sign bit differs from it
REQ-018 Latency SHALL be 1 cycle: out_valid SHALL rise on the edge that samples in_valid=1, together with the new Z and flags.
REQ-019 On an edge with in_valid=0, out_valid SHALL go to 0, and Z and all flags SHALL hold their previous values.
REQ-020 Back-to-back operations (in_valid high on consecutive cycles) SHALL each produce a result on the following edge; there is no stall or backpressure.
REQ-021 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force Z=0, S=0, ZR=0, CY=0, P=0, V=0 and out_valid=0, regardless of clk.
REQ-023 Reset asserted mid-operation SHALL discard the pending result; the first operation is accepted on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-024 The macro ALU16_SUB_EN SHALL control the subtract feature:
- Defined: port sub exists. With sub=1, Z = X + ~Y + 1 (modulo 2^WIDTH) and CY = borrow, i.e. 1 when X < Y unsigned. V = 1 when X and Y have different sign bits and Z's sign bit differs from X's. S, ZR and P follow REQ-017. With sub=0, behaviour is identical to the add path.
- Undefined: port sub is absent and only addition is implemented.

Verification
REQ-025 X=8FFF, Y=8000, in_valid=1 -> next edge: Z=0FFF, S=0, ZR=0, CY=1, P=1, V=1, out_valid=1.
REQ-026 X=FFFE, Y=0002 -> Z=0000, S=0, ZR=1, CY=1, P=1, V=0.
REQ-027 X=AAAA, Y=5555 -> Z=FFFF, S=1, ZR=0, CY=0, P=1, V=0; then X=7FFF, Y=0001 -> Z=8000, S=1, CY=0, P=0, V=1.
REQ-028 in_valid pulse followed by 3 idle cycles -> out_valid high for exactly one cycle, and Z and flags hold their values during the idle cycles.
REQ-029 Assert rst_n=0 asynchronously between clk edges while Z=FFFF -> all outputs 0 immediately; then release, apply X=0001, Y=0001 -> Z=0002, P=0.
REQ-030 With ALU16_SUB_EN defined: sub=1, X=0001, Y=0002 -> Z=FFFF, CY=1, S=1, V=0; sub=1, X=8000, Y=0001 -> Z=7FFF, CY=0, V=1.
